// File: rtl/eq_serial_pkg_amisha.sv
// eq_serial_pkg_amisha: shared state encoding and width limits for the bit-serial equality checker
package eq_serial_pkg_amisha;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int W_MIN = 2;
    localparam int W_MAX = 64;

endpackage

// File: rtl/eq1_cell_amisha.sv
// eq1_cell_amisha: combinational 1-bit equality cell shared across all bit positions
module eq1_cell_amisha (
    input  logic i_x,
    input  logic i_y,
    output logic o_eq
);

    // XNOR written as the explicit sum of both-zero and both-one terms
    always_comb o_eq = (~i_x & ~i_y) | (i_x & i_y);

endmodule

// File: rtl/eq_serial_ctrl_amisha.sv
// eq_serial_ctrl_amisha: bit-serial N-bit equality checker (optional early exit via EQ_EARLY_EXIT_EN)
module eq_serial_ctrl_amisha
    import eq_serial_pkg_amisha::*;
#(
    parameter int W  = 8,
    parameter int IW = $clog2(W)
) (
    input  logic          clk_amisha,
    input  logic          reset_n_amisha,
    input  logic          start_amisha,
    input  logic [W-1:0]  a_amisha,
    input  logic [W-1:0]  b_amisha,
    output logic          busy_amisha,
    output logic          done_amisha,
    output logic          eq_amisha,
    output logic [IW-1:0] mismatch_idx_amisha
);

    if (W < W_MIN || W > W_MAX) begin : g_bad_w
        $error("eq_serial_ctrl_amisha: W out of range");
    end

    state_t        r_state;
    state_t        w_state_nxt;
    logic [W-1:0]  r_a_sh;
    logic [W-1:0]  r_b_sh;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] r_mm_idx;
    logic [IW-1:0] r_mismatch_idx;
    logic          r_acc;
    logic          r_found;
    logic          r_eq;
    logic          w_cell_eq;
    logic          w_acc_nxt;
    logic          w_first_mm;
    logic          w_last;
    logic          w_exit;
    logic [IW-1:0] w_mm_nxt;

    eq1_cell_amisha u_cell (
        .i_x  (r_a_sh[0]),
        .i_y  (r_b_sh[0]),
        .o_eq (w_cell_eq)
    );

    // per-bit accumulation and scan termination
    always_comb begin
        w_acc_nxt  = r_acc & w_cell_eq;
        w_first_mm = ~r_found & ~w_cell_eq;
        w_mm_nxt   = w_first_mm ? r_idx : r_mm_idx;
        w_last     = (r_idx == IW'(W - 1));
`ifdef EQ_EARLY_EXIT_EN
        w_exit     = w_last | w_first_mm;
`else
        w_exit     = w_last;
`endif
    end

    // next-state logic and outputs decoded from the state register
    always_comb begin
        w_state_nxt         = r_state;
        busy_amisha         = (r_state != IDLE);
        done_amisha         = (r_state == DONE);
        eq_amisha           = r_eq;
        mismatch_idx_amisha = r_mismatch_idx;
        case (r_state)
            IDLE:    w_state_nxt = start_amisha ? SCAN : IDLE;
            SCAN:    w_state_nxt = w_exit ? DONE : SCAN;
            default: w_state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk_amisha) begin
        if (!reset_n_amisha)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // operand capture, serial shift, accumulation and result registers
    always_ff @(posedge clk_amisha) begin
        if (!reset_n_amisha) begin
            r_a_sh         <= '0;
            r_b_sh         <= '0;
            r_idx          <= '0;
            r_mm_idx       <= '0;
            r_acc          <= 1'b0;
            r_found        <= 1'b0;
            r_eq           <= 1'b0;
            r_mismatch_idx <= '0;
        end else if (r_state == IDLE && start_amisha) begin
            r_a_sh   <= a_amisha;
            r_b_sh   <= b_amisha;
            r_idx    <= '0;
            r_mm_idx <= '0;
            r_acc    <= 1'b1;
            r_found  <= 1'b0;
        end else if (r_state == SCAN) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_idx    <= w_last ? r_idx : r_idx + IW'(1);
            r_acc    <= w_acc_nxt;
            r_found  <= r_found | ~w_cell_eq;
            r_mm_idx <= w_mm_nxt;
            if (w_exit) begin
                r_eq           <= w_acc_nxt;
                r_mismatch_idx <= w_mm_nxt;
            end
        end
    end

endmodule

// File: tb/tb_eq_serial_ctrl_amisha.sv
// tb_eq_serial_ctrl_amisha: scoreboard bench for the bit-serial equality checker (honours EQ_EARLY_EXIT_EN)
module tb_eq_serial_ctrl_amisha;

    localparam int W  = 8;
    localparam int IW = $clog2(W);

    typedef struct {
        logic          eq;
        logic [IW-1:0] idx;
        int            cyc;
    } exp_t;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
    logic          busy;
    logic          done;
    logic          eq;
    logic [IW-1:0] idx;

    int            tests = 0;
    int            fails = 0;
    int            cyc   = 0;
    exp_t          q[$];
    logic          held_eq  = 1'b0;
    logic [IW-1:0] held_idx = '0;

    eq_serial_ctrl_amisha #(.W(W)) dut (
        .clk_amisha          (clk),
        .reset_n_amisha      (reset_n),
        .start_amisha        (start),
        .a_amisha            (a_in),
        .b_amisha            (b_in),
        .busy_amisha         (busy),
        .done_amisha         (done),
        .eq_amisha           (eq),
        .mismatch_idx_amisha (idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int c);
        exp_t         e;
        logic [W-1:0] d   = a ^ b;
        int           lat = W;
        e.eq  = (a == b);
        e.idx = '0;
        for (int i = W - 1; i >= 0; i--)
            if (d[i]) e.idx = IW'(i);
`ifdef EQ_EARLY_EXIT_EN
        if (!e.eq) lat = int'(e.idx) + 1;
`endif
        e.cyc = c + lat;
        return e;
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold, input int gap, input bit noise);
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 4 * W) begin
            start = noise ? 1'($urandom) : 1'b0;
            if (noise) begin
                a_in = W'($urandom);
                b_in = W'($urandom);
            end
            n++;
            @(negedge clk);
        end
        if (n >= 4 * W) check("wait_idle_timeout", 1, 0);
        start = 1'b0;
        repeat (gap) @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        q.push_back(model(a, b, cyc + 1));
        @(negedge clk);
        check("busy_after_accept", busy, 1);
        if (hold) begin
            n = 0;
            while (busy !== 1'b0 && n < 4 * W) begin
                n++;
                @(negedge clk);
            end
            if (n >= 4 * W) check("hold_wait_timeout", 1, 0);
            q.push_back(model(a, b, cyc + 1));
            @(negedge clk);
            check("busy_after_held_start", busy, 1);
        end
        start = 1'b0;
    endtask

    initial begin
        bit   prev_done = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (prev_done) check("idle_after_done", busy, 0);
            if (done === 1'b1) begin
                check("busy_in_done", busy, 1);
                if (q.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("eq", eq, e.eq);
                    check("mismatch_idx", idx, e.idx);
                    check("done_cycle", cyc, e.cyc);
                    held_eq  = e.eq;
                    held_idx = e.idx;
                end
            end else begin
                check("eq_held", eq, held_eq);
                check("idx_held", idx, held_idx);
            end
            prev_done = (done === 1'b1);
        end
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           n;
        reset_n = 1'b0;
        start   = 1'b0;
        a_in    = '0;
        b_in    = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        reset_n = 1'b1;
        issue(8'hA5, 8'hA5, 1'b0, 1, 1'b0);
        issue(8'hA5, 8'hA4, 1'b0, 0, 1'b0);
        issue(8'h80, 8'h00, 1'b0, 2, 1'b0);
        issue(8'h0F, 8'h3F, 1'b1, 0, 1'b0);
        issue(8'h12, 8'h12, 1'b0, 0, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        q.delete();
        held_eq  = 1'b0;
        held_idx = '0;
        @(negedge clk);
        check("midscan_reset_busy", busy, 0);
        check("midscan_reset_done", done, 0);
        reset_n = 1'b1;
        issue(8'h3C, 8'h3D, 1'b0, 0, 1'b0);
        issue(8'hFF, 8'hFF, 1'b0, 0, 1'b0);
        issue(8'h01, 8'h81, 1'b0, 0, 1'b1);
        for (int t = 0; t < 150; t++) begin
            ra = W'($urandom);
            case ($urandom % 4)
                0:       rb = ra;
                1:       rb = ra ^ (W'(1) << ($urandom % W));
                default: rb = W'($urandom);
            endcase
            issue(ra, rb, ($urandom % 10) == 0, $urandom % 3, 1'b1);
        end
        start = 1'b0;
        n = 0;
        while (q.size() > 0 && n < 4 * W) begin
            n++;
            @(negedge clk);
        end
        if (q.size() > 0) check("drain_timeout", q.size(), 0);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
